spi_master_gen: RTL and testbench

Parametrised, buffered SPI master for the ILI9341 display path: accepts `{dc, data}` words into an internal TX FIFO and serialises them on SCLK/MOSI with a programmable divider, SPI mode (CPOL/CPHA) and word width. CS stays low for back-to-back words, so command-plus-parameter sequences go out as one burst. Each received MISO word is returned with a one-cycle valid strobe. It replaces the fixed 8-bit divider/control/shift chain beneath the display command sequencer.

---
 rtl/spi_master_gen_pkg.sv | 22 ++
 rtl/spi_master_gen_fifo.sv | 50 +++++
 rtl/spi_master_gen.sv | 201 ++++++++++++++++++++
 tb/tb_spi_master_gen.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/spi_master_gen_pkg.sv
// Shared types for the ILI9341 SPI path: FSM states, SPI mode encoding and
// a counter-width helper.
package pkg_ili9341;

   typedef enum logic [1:0] {IDLE, SETUP, XFER, HOLD} spi_state_e;

   typedef struct packed {
      logic cpol;
      logic cpha;
   } spi_mode_t;

   localparam spi_mode_t SPI_MODE0 = '{cpol: 1'b0, cpha: 1'b0};
   localparam spi_mode_t SPI_MODE1 = '{cpol: 1'b0, cpha: 1'b1};
   localparam spi_mode_t SPI_MODE2 = '{cpol: 1'b1, cpha: 1'b0};
   localparam spi_mode_t SPI_MODE3 = '{cpol: 1'b1, cpha: 1'b1};

   // Width of a counter that must hold 0..n-1, never narrower than one bit.
   function automatic int cnt_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/spi_master_gen_fifo.sv
// Show-ahead synchronous TX FIFO; writes into a full FIFO are dropped even
// when a read happens in the same cycle.
module spi_tx_fifo #(
   parameter int WIDTH = 9,
   parameter int DEPTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr,
   input  logic [WIDTH-1:0] wdata,
   input  logic             rd,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr, rd_ptr;
   logic [CW-1:0]    count, count_nxt;
   logic             push, pop;

   assign push      = wr && !full;
   assign pop       = rd && !empty;
   assign count_nxt = count + CW'(push) - CW'(pop);
   assign rdata     = mem[rd_ptr];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         full   <= 1'b0;
         empty  <= 1'b1;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         count <= count_nxt;
         full  <= (count_nxt == CW'(DEPTH));
         empty <= (count_nxt == '0);
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= wdata;
   end

endmodule

// File: rtl/spi_master_gen.sv
// Buffered SPI master for the ILI9341 path: FIFO-fed words go out as one
// CS-low burst with programmable mode, divider and word width.
module spi_master_gen
   import pkg_ili9341::*;
#(
   parameter int DATA_W     = 8,
   parameter int DIV        = 4,
   parameter int FIFO_DEPTH = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [1:0]        i_mode,
   input  logic              i_wr,
   input  logic [DATA_W-1:0] i_wdata,
   input  logic              i_wdc,
   output logic              o_full,
   output logic              o_empty,
   output logic              o_busy,
   output logic [DATA_W-1:0] o_rdata,
   output logic              o_rvalid,
   input  logic              miso,
   output logic              sclk,
   output logic              mosi,
   output logic              dc,
   output logic              cs
);

   localparam int DW = cnt_w(DIV);
   localparam int BW = cnt_w(DATA_W);

   spi_state_e        state, state_nxt;
   spi_mode_t         mode_q, mode_nxt;
   logic [DW-1:0]     div_cnt, div_nxt;
   logic [BW-1:0]     bit_cnt, bit_nxt;
   logic              half_q, half_nxt, nxt_vld, nxt_vld_nxt;
   logic [DATA_W-1:0] tx_sh, tx_nxt, rx_sh, rx_nxt, rdata_nxt;
   logic [DATA_W-1:0] tx_shl, rx_shift, load_tx;
   logic              sclk_nxt, mosi_nxt, dc_nxt, cs_nxt, rvalid_nxt;
   logic              fifo_rd, cpha_ld, div_end, bit_last;
   logic [DATA_W:0]   head;

   spi_tx_fifo #(.WIDTH(DATA_W + 1), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk  (clk),
      .rst  (rst),
      .wr   (i_wr),
      .wdata({i_wdc, i_wdata}),
      .rd   (fifo_rd),
      .rdata(head),
      .full (o_full),
      .empty(o_empty)
   );

   assign div_end  = (div_cnt == DW'(DIV - 1));
   assign bit_last = (bit_cnt == BW'(DATA_W - 1));
   assign tx_shl   = {tx_sh[DATA_W-2:0], 1'b0};
   assign rx_shift = {rx_sh[DATA_W-2:0], miso};
   // CPHA=0 presents the MSB before the first edge, so the shifter starts one bit ahead.
   assign cpha_ld  = (state == IDLE) ? i_mode[0] : mode_q.cpha;
   assign load_tx  = cpha_ld ? head[DATA_W-1:0] : {head[DATA_W-2:0], 1'b0};

   always_comb begin
      state_nxt   = state;
      mode_nxt    = mode_q;
      div_nxt     = div_cnt;
      bit_nxt     = bit_cnt;
      half_nxt    = half_q;
      nxt_vld_nxt = nxt_vld;
      tx_nxt      = tx_sh;
      rx_nxt      = rx_sh;
      rdata_nxt   = o_rdata;
      rvalid_nxt  = 1'b0;
      sclk_nxt    = sclk;
      mosi_nxt    = mosi;
      dc_nxt      = dc;
      cs_nxt      = cs;
      fifo_rd     = 1'b0;
      case (state)
         IDLE: begin
            cs_nxt   = 1'b1;
            sclk_nxt = mode_q.cpol;
            if (!o_empty) begin
               state_nxt = SETUP;
               mode_nxt  = spi_mode_t'(i_mode);
               cs_nxt    = 1'b0;
               sclk_nxt  = i_mode[1];
               div_nxt   = '0;
               bit_nxt   = '0;
               fifo_rd   = 1'b1;
               dc_nxt    = head[DATA_W];
               mosi_nxt  = head[DATA_W-1];
               tx_nxt    = load_tx;
            end
         end
         SETUP: begin
            if (!div_end) div_nxt = div_cnt + 1'b1;
            else begin
               state_nxt   = XFER;
               div_nxt     = '0;
               half_nxt    = 1'b0;
               nxt_vld_nxt = 1'b0;
               sclk_nxt    = ~mode_q.cpol;
               if (mode_q.cpha) begin
                  mosi_nxt = tx_sh[DATA_W-1];
                  tx_nxt   = tx_shl;
               end else rx_nxt = rx_shift;
            end
         end
         XFER: begin
            if (!div_end) div_nxt = div_cnt + 1'b1;
            else begin
               div_nxt = '0;
               if (!half_q) begin
                  half_nxt = 1'b1;
                  sclk_nxt = mode_q.cpol;
                  if (mode_q.cpha) begin
                     rx_nxt = rx_shift;
                     if (bit_last) begin
                        rdata_nxt  = rx_shift;
                        rvalid_nxt = 1'b1;
                     end
                  end
                  if (!bit_last) begin
                     if (!mode_q.cpha) begin
                        mosi_nxt = tx_sh[DATA_W-1];
                        tx_nxt   = tx_shl;
                     end
                  end else if (!o_empty) begin
                     // Next word is staged during the last trailing half so it starts gap-free.
                     fifo_rd     = 1'b1;
                     dc_nxt      = head[DATA_W];
                     tx_nxt      = load_tx;
                     nxt_vld_nxt = 1'b1;
                     if (!mode_q.cpha) mosi_nxt = head[DATA_W-1];
                  end
               end else if (!bit_last || nxt_vld) begin
                  half_nxt    = 1'b0;
                  sclk_nxt    = ~mode_q.cpol;
                  nxt_vld_nxt = 1'b0;
                  bit_nxt     = bit_last ? '0 : bit_cnt + 1'b1;
                  if (mode_q.cpha) begin
                     mosi_nxt = tx_sh[DATA_W-1];
                     tx_nxt   = tx_shl;
                  end else begin
                     rx_nxt = rx_shift;
                     if (!bit_last && bit_cnt == BW'(DATA_W - 2)) begin
                        rdata_nxt  = rx_shift;
                        rvalid_nxt = 1'b1;
                     end
                  end
               end else state_nxt = HOLD;
            end
         end
         HOLD: begin
            if (!div_end) div_nxt = div_cnt + 1'b1;
            else begin
               div_nxt   = '0;
               cs_nxt    = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= IDLE;
         mode_q   <= SPI_MODE0;
         div_cnt  <= '0;
         bit_cnt  <= '0;
         half_q   <= 1'b0;
         nxt_vld  <= 1'b0;
         tx_sh    <= '0;
         rx_sh    <= '0;
         o_rdata  <= '0;
         o_rvalid <= 1'b0;
         o_busy   <= 1'b0;
         sclk     <= 1'b0;
         mosi     <= 1'b0;
         dc       <= 1'b0;
         cs       <= 1'b1;
      end else begin
         state    <= state_nxt;
         mode_q   <= mode_nxt;
         div_cnt  <= div_nxt;
         bit_cnt  <= bit_nxt;
         half_q   <= half_nxt;
         nxt_vld  <= nxt_vld_nxt;
         tx_sh    <= tx_nxt;
         rx_sh    <= rx_nxt;
         o_rdata  <= rdata_nxt;
         o_rvalid <= rvalid_nxt;
         o_busy   <= (state_nxt != IDLE);
         sclk     <= sclk_nxt;
         mosi     <= mosi_nxt;
         dc       <= dc_nxt;
         cs       <= cs_nxt;
      end
   end

endmodule

// File: tb/tb_spi_master_gen.sv
// Directed bench for spi_master_gen: 8-bit/DIV=2 and 16-bit/DIV=1 instances
// with MISO looped back to MOSI, plus a bus monitor acting as the slave.
module tb_spi_master_gen;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic [1:0] i_mode;
   logic       i_wr, i_wdc;
   logic [7:0] i_wdata, o_rdata;
   logic       o_full, o_empty, o_busy, o_rvalid, miso, sclk, mosi, dc, cs;

   logic        i_wr16;
   logic [15:0] i_wdata16, o_rdata16;
   logic        o_full16, o_empty16, o_busy16, o_rvalid16, miso16, sclk16, mosi16, dc16, cs16;

   assign miso   = mosi;
   assign miso16 = mosi16;

   spi_master_gen #(.DATA_W(8), .DIV(2), .FIFO_DEPTH(8)) dut (
      .clk(clk), .rst(rst), .i_mode(i_mode), .i_wr(i_wr), .i_wdata(i_wdata), .i_wdc(i_wdc),
      .o_full(o_full), .o_empty(o_empty), .o_busy(o_busy), .o_rdata(o_rdata),
      .o_rvalid(o_rvalid), .miso(miso), .sclk(sclk), .mosi(mosi), .dc(dc), .cs(cs));

   spi_master_gen #(.DATA_W(16), .DIV(1), .FIFO_DEPTH(8)) dut16 (
      .clk(clk), .rst(rst), .i_mode(2'b00), .i_wr(i_wr16), .i_wdata(i_wdata16), .i_wdc(1'b0),
      .o_full(o_full16), .o_empty(o_empty16), .o_busy(o_busy16), .o_rdata(o_rdata16),
      .o_rvalid(o_rvalid16), .miso(miso16), .sclk(sclk16), .mosi(mosi16), .dc(dc16), .cs(cs16));

   int errors = 0;
   int checks = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Slave-side monitor: captures MOSI just before each sampling SCLK edge.
   logic       mon_clr;
   logic [1:0] cur_mode;
   int         cs_low, cs_rise, nbits, hold_err, dc_err, dc_rise, rv_cnt, cs16_low, rv16;
   logic [7:0] mshift;
   logic       word_dc, cs_p, sclk_p, mosi_p, dc_p;
   logic [8:0] words[$];
   logic [7:0] rdq[$];

   always @(negedge clk) begin
      if (mon_clr) begin
         cs_low = 0; cs_rise = 0; nbits = 0; hold_err = 0; dc_err = 0; dc_rise = 0;
         rv_cnt = 0; cs16_low = 0; rv16 = 0;
         words.delete(); rdq.delete();
      end else begin
         if (!cs) cs_low++;
         if (cs && !cs_p) cs_rise++;
         if (dc && !dc_p) dc_rise++;
         if (dc != dc_p && sclk != cur_mode[1]) dc_err++;
         if (!cs && !cs_p && sclk != sclk_p && ((sclk != cur_mode[1]) == !cur_mode[0])) begin
            if (mosi != mosi_p) hold_err++;
            if (nbits % 8 == 0) word_dc = dc;
            else if (dc != word_dc) dc_err++;
            mshift = {mshift[6:0], mosi_p};
            nbits++;
            if (nbits % 8 == 0) words.push_back({word_dc, mshift});
         end
         if (o_rvalid) begin rv_cnt++; rdq.push_back(o_rdata); end
         if (!cs16) cs16_low++;
         if (o_rvalid16) rv16++;
      end
      cs_p = cs; sclk_p = sclk; mosi_p = mosi; dc_p = dc;
   end

   task automatic clear_mon();
      mon_clr = 1'b1;
      repeat (2) @(negedge clk);
      mon_clr = 1'b0;
   endtask

   task automatic wr_word(input logic wdc, input logic [7:0] data);
      i_wr = 1'b1; i_wdc = wdc; i_wdata = data;
      @(negedge clk);
      i_wr = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      int n = 0;
      while ((o_busy || !o_empty || o_busy16 || !o_empty16) && n < 2000) begin
         @(negedge clk);
         n++;
      end
      chk({name, "_done_in_time"}, 32'(n < 2000), 32'd1);
      repeat (3) @(negedge clk);
   endtask

   typedef struct {
      logic [1:0] mode;
      logic [7:0] data;
      logic       wdc;
      logic [7:0] exp_rd;
      int         exp_cs;
   } vec_t;

   vec_t       vt[6];
   logic [8:0] burst_w[5];

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      // Loopback: received word equals the sent word; cs low = DIV + 2*DIV*8 + DIV.
      vt[0] = '{2'd0, 8'hA5, 1'b0, 8'hA5, 36};
      vt[1] = '{2'd1, 8'hA5, 1'b1, 8'hA5, 36};
      vt[2] = '{2'd2, 8'hA5, 1'b0, 8'hA5, 36};
      vt[3] = '{2'd3, 8'hA5, 1'b1, 8'hA5, 36};
      vt[4] = '{2'd0, 8'h3C, 1'b1, 8'h3C, 36};
      vt[5] = '{2'd3, 8'h81, 1'b0, 8'h81, 36};
      burst_w = '{9'h02A, 9'h100, 9'h100, 9'h100, 9'h1EF};

      rst = 1'b0; i_mode = 2'b00; i_wr = 1'b0; i_wdc = 1'b0; i_wdata = '0;
      i_wr16 = 1'b0; i_wdata16 = '0; cur_mode = 2'b00; mon_clr = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_cs", 32'(cs), 32'd1);
      chk("rst_sclk", 32'(sclk), 32'd0);
      chk("rst_mosi", 32'(mosi), 32'd0);
      chk("rst_dc", 32'(dc), 32'd0);
      chk("rst_full", 32'(o_full), 32'd0);
      chk("rst_empty", 32'(o_empty), 32'd1);
      chk("rst_busy", 32'(o_busy), 32'd0);
      chk("rst_rvalid", 32'(o_rvalid), 32'd0);
      chk("rst_rdata", 32'(o_rdata), 32'd0);
      rst = 1'b1;
      clear_mon();

      for (int v = 0; v < 6; v++) begin
         cur_mode = vt[v].mode; i_mode = vt[v].mode;
         clear_mon();
         wr_word(vt[v].wdc, vt[v].data);
         chk($sformatf("v%0d_cs_high_after_write", v), 32'(cs), 32'd1);
         @(negedge clk);
         chk($sformatf("v%0d_cs_fall", v), 32'(cs), 32'd0);
         i_mode = ~vt[v].mode;
         wait_idle($sformatf("v%0d", v));
         chk($sformatf("v%0d_cs_low", v), 32'(cs_low), 32'(vt[v].exp_cs));
         chk($sformatf("v%0d_cs_rise", v), 32'(cs_rise), 32'd1);
         chk($sformatf("v%0d_bits", v), 32'(nbits), 32'd8);
         if (words.size() > 0)
            chk($sformatf("v%0d_mosi_word", v), 32'(words[0]), 32'({vt[v].wdc, vt[v].data}));
         chk($sformatf("v%0d_rvalid_cnt", v), 32'(rv_cnt), 32'd1);
         chk($sformatf("v%0d_rdata", v), 32'(o_rdata), 32'(vt[v].exp_rd));
         chk($sformatf("v%0d_hold", v), 32'(hold_err), 32'd0);
         chk($sformatf("v%0d_dc_rule", v), 32'(dc_err), 32'd0);
         chk($sformatf("v%0d_sclk_idle", v), 32'(sclk), 32'(vt[v].mode[1]));
      end

      // Command + four parameters in one burst.
      cur_mode = 2'd0; i_mode = 2'd0;
      clear_mon();
      for (int i = 0; i < 5; i++) wr_word(burst_w[i][8], burst_w[i][7:0]);
      wait_idle("burst");
      chk("burst_cs_low", 32'(cs_low), 32'd164);
      chk("burst_cs_rise", 32'(cs_rise), 32'd1);
      chk("burst_words", 32'(words.size()), 32'd5);
      for (int i = 0; i < 5; i++)
         if (words.size() > i) chk($sformatf("burst_word%0d", i), 32'(words[i]), 32'(burst_w[i]));
      chk("burst_rvalid_cnt", 32'(rv_cnt), 32'd5);
      chk("burst_dc_rise", 32'(dc_rise), 32'd1);
      chk("burst_dc_rule", 32'(dc_err), 32'd0);
      chk("burst_hold", 32'(hold_err), 32'd0);

      // The first word leaves the FIFO when the burst starts, so 9 writes fill it; the 10th is dropped.
      clear_mon();
      for (int i = 0; i < 10; i++) begin
         wr_word(1'b1, 8'(8'h10 + i));
         if (i == 8) chk("fill_full", 32'(o_full), 32'd1);
      end
      chk("fill_full_after_drop", 32'(o_full), 32'd1);
      wait_idle("fill");
      chk("fill_words", 32'(words.size()), 32'd9);
      for (int i = 0; i < 9; i++)
         if (rdq.size() > i) chk($sformatf("fill_rdata%0d", i), 32'(rdq[i]), 32'(8'h10 + i));
      chk("fill_rvalid_cnt", 32'(rv_cnt), 32'd9);
      chk("fill_cs_low", 32'(cs_low), 32'd292);

      // Reset in the middle of bit 4 with a second word still queued.
      clear_mon();
      wr_word(1'b0, 8'h5A);
      wr_word(1'b0, 8'h77);
      begin
         int n = 0;
         while (nbits < 5 && n < 200) begin @(negedge clk); n++; end
         chk("rst_mid_reached_bit4", 32'(n < 200), 32'd1);
      end
      rst = 1'b0;
      #1;
      chk("rst_mid_cs", 32'(cs), 32'd1);
      chk("rst_mid_sclk", 32'(sclk), 32'd0);
      chk("rst_mid_empty", 32'(o_empty), 32'd1);
      chk("rst_mid_busy", 32'(o_busy), 32'd0);
      chk("rst_mid_rdata", 32'(o_rdata), 32'd0);
      @(negedge clk);
      chk("rst_mid_no_rvalid", 32'(rv_cnt), 32'd0);
      rst = 1'b1;
      clear_mon();
      wr_word(1'b1, 8'hC3);
      wait_idle("post_rst");
      chk("post_rst_words", 32'(words.size()), 32'd1);
      if (words.size() > 0) chk("post_rst_word", 32'(words[0]), 32'h1C3);
      chk("post_rst_rdata", 32'(o_rdata), 32'hC3);
      chk("post_rst_cs_low", 32'(cs_low), 32'd36);

      // 16-bit word at DIV=1: 1 + 32 + 1 cycles with cs low.
      clear_mon();
      i_wr16 = 1'b1; i_wdata16 = 16'h8001;
      @(negedge clk);
      i_wr16 = 1'b0;
      wait_idle("w16");
      chk("w16_cs_low", 32'(cs16_low), 32'd34);
      chk("w16_rvalid_cnt", 32'(rv16), 32'd1);
      chk("w16_rdata", 32'(o_rdata16), 32'h8001);
      chk("w16_sclk_idle", 32'(sclk16), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
